// File: rtl/bus_master.sv
// CPU-side initiator for the 8-bit four-phase SoC bus; splits 16-bit word requests into two byte cycles.
// Optional strobe timeout is compiled in with `define BUS_TIMEOUT_EN.
module bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_error,
  output logic [15:0] bus_address_out,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic        bus_read,
  output logic        bus_write,
  input  logic        bus_done
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("bus_master: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RELEASE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        write_q, word_q, byte1_q;
  logic [15:0] wdata_q;
  logic        accept, abort, err_flag, write_sel;

  assign accept    = (state == IDLE) && req_valid && req_ready;
  // Strobe type for the next cycle must come from the request itself on the accepting edge.
  assign write_sel = accept ? req_write : write_q;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt;
  logic       err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      // Held at zero outside STROBE, so every strobe (byte 0 or byte 1) starts a fresh count.
      if (state != STROBE)
        tmo_cnt <= 8'd0;
      else if (!bus_done)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (accept)
        err_q <= 1'b0;
      else if (abort)
        err_q <= 1'b1;
    end
  end

  assign abort    = (state == STROBE) && !bus_done && (tmo_cnt == TMO_LAST);
  assign err_flag = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      resp_error <= 1'b0;
    else
      resp_error <= (state_next == RESP) && err_q;
  end
`else
  assign abort      = 1'b0;
  assign err_flag   = 1'b0;
  assign resp_error = 1'b0;
`endif

  // NOTE: every signal assigned in always_comb gets a default first; a path that skips one infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = STROBE;
      STROBE:  if (bus_done || abort) state_next = RELEASE;
      RELEASE: begin
        if (!bus_done)
          state_next = (word_q && !byte1_q && !err_flag) ? STROBE : RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      write_q         <= 1'b0;
      word_q          <= 1'b0;
      byte1_q         <= 1'b0;
      wdata_q         <= 16'h0000;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_rdata      <= 16'h0000;
      bus_address_out <= 16'h0000;
      bus_data_out    <= 8'h00;
      bus_read        <= 1'b0;
      bus_write       <= 1'b0;
    end else begin
      state      <= state_next;
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      bus_read   <= (state_next == STROBE) && !write_sel;
      bus_write  <= (state_next == STROBE) && write_sel;

      if (accept) begin
        write_q         <= req_write;
        word_q          <= req_word;
        byte1_q         <= 1'b0;
        wdata_q         <= req_wdata;
        bus_address_out <= req_addr;
        bus_data_out    <= req_wdata[7:0];
        resp_rdata      <= 16'h0000;
      end

      if ((state == STROBE) && bus_done && !write_q) begin
        if (byte1_q)
          resp_rdata[15:8] <= bus_data_in;
        else
          resp_rdata[7:0]  <= bus_data_in;
      end

      // Second byte of a word: address wraps naturally at 16 bits.
      if ((state == RELEASE) && (state_next == STROBE)) begin
        byte1_q         <= 1'b1;
        bus_address_out <= bus_address_out + 16'd1;
        bus_data_out    <= wdata_q[15:8];
      end
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master with a behavioural four-phase responder.
// Define BUS_TIMEOUT_EN for both files to exercise the strobe timeout.
module tb_bus_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_word = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_wdata = 16'h0000;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_error;
  logic [15:0] bus_address_out;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_in;
  logic        bus_read;
  logic        bus_write;
  logic        bus_done;

  int n_checks = 0;
  int n_errors = 0;

  bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
    .bus_data_in(bus_data_in), .bus_read(bus_read), .bus_write(bus_write),
    .bus_done(bus_done)
  );

  always #5 clk = ~clk;

  // Responder: done follows a strobe by one cycle and lingers extra_hold cycles after it drops.
  int          extra_hold = 0;
  logic        mute = 1'b0;
  int          hold_cnt;
  logic [25:0] xfer_log[$];   // {rd, wr, addr, data} per strobe

  always_comb begin
    case (bus_address_out)
      16'h1234: bus_data_in = 8'h3E;
      16'h2000: bus_data_in = 8'h22;
      16'h2001: bus_data_in = 8'h11;
      default:  bus_data_in = 8'hA5;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_done <= 1'b0;
      hold_cnt <= 0;
    end else if (mute) begin
      bus_done <= 1'b0;
    end else if (bus_read || bus_write) begin
      if (!bus_done)
        xfer_log.push_back({bus_read, bus_write, bus_address_out, bus_data_out});
      bus_done <= 1'b1;
      hold_cnt <= extra_hold;
    end else if (hold_cnt != 0) begin
      hold_cnt <= hold_cnt - 1;
    end else begin
      bus_done <= 1'b0;
    end
  end

  // Protocol monitors: strobe overlap, and a strobe rising while done is still high.
  int   overlap_cnt = 0;
  int   early_strobe_cnt = 0;
  logic prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (bus_read && bus_write) overlap_cnt++;
    if ((bus_read || bus_write) && !prev_strobe && bus_done) early_strobe_cnt++;
    prev_strobe = bus_read || bus_write;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request and returns 1 ns after the accepting edge, then scrambles the inputs.
  task automatic start_req(input logic w, input logic wd, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_accept", req_ready, 1);
    xfer_log.delete();
    req_valid = 1'b1;
    req_write = w;
    req_word  = wd;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~w;
    req_word  = ~wd;
    req_addr  = 16'hDEAD;
    req_wdata = 16'h0BAD;
  endtask

  // k = negedges after acceptance until resp_valid is seen (0 = first cycle after acceptance).
  task automatic wait_resp(output int k, output int rd_cyc, output int wr_cyc);
    k = 0;
    rd_cyc = 0;
    wr_cyc = 0;
    forever begin
      @(negedge clk);
      if (bus_read) rd_cyc++;
      if (bus_write) wr_cyc++;
      if (resp_valid || k > 200) break;
      k++;
    end
  endtask

  initial begin
    int k, rd_cyc, wr_cyc, seen;

    // Reset values while rst_n is low.
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_error", resp_error, 0);
    check("rst_bus_addr", bus_address_out, 0);
    check("rst_bus_data", bus_data_out, 0);
    check("rst_strobes", {bus_read, bus_write}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Byte read at 0x1234: strobe 2 cycles, resp in cycle 5 after acceptance.
    start_req(1'b0, 1'b0, 16'h1234, 16'h0000);
    check("byte_rd_strobe_on", {bus_read, bus_write}, 2'b10);
    check("byte_rd_addr", bus_address_out, 16'h1234);
    wait_resp(k, rd_cyc, wr_cyc);
    check("byte_rd_latency", k, 4);
    check("byte_rd_strobe_cycles", rd_cyc, 2);
    check("byte_rd_rdata", resp_rdata, 16'h003E);
    check("byte_rd_error", resp_error, 0);
    check("byte_rd_log", xfer_log.size() == 1 ? xfer_log[0] : 26'h3FFFFFF, {2'b10, 16'h1234, 8'h00});
    @(negedge clk);
    check("byte_rd_pulse_one_cycle", resp_valid, 0);
    check("byte_rd_ready_again", req_ready, 1);
    check("byte_rd_rdata_held", resp_rdata, 16'h003E);

    // Word write 0xBEEF at 0xFFFF: 0xEF to 0xFFFF, then 0xBE to 0x0000 (wrap).
    start_req(1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
    wait_resp(k, rd_cyc, wr_cyc);
    check("word_wr_latency", k, 8);
    check("word_wr_strobe_cycles", wr_cyc, 4);
    check("word_wr_no_read", rd_cyc, 0);
    check("word_wr_log_size", xfer_log.size(), 2);
    if (xfer_log.size() == 2) begin
      check("word_wr_byte0", xfer_log[0], {2'b01, 16'hFFFF, 8'hEF});
      check("word_wr_byte1", xfer_log[1], {2'b01, 16'h0000, 8'hBE});
    end
    check("word_wr_error", resp_error, 0);

    // Slow release: done lingers 3 cycles past strobe removal.
    extra_hold = 3;
    start_req(1'b0, 1'b1, 16'h2000, 16'h0000);
    wait_resp(k, rd_cyc, wr_cyc);
    check("slow_word_rd_latency", k, 14);
    check("slow_word_rd_strobe_cycles", rd_cyc, 4);
    check("slow_word_rd_rdata", resp_rdata, 16'h1122);
    check("slow_word_rd_log_size", xfer_log.size(), 2);
    if (xfer_log.size() == 2)
      check("slow_word_rd_byte1_addr", xfer_log[1][23:8], 16'h2001);
    extra_hold = 0;
    repeat (6) @(negedge clk);

    // Reset mid-STROBE of a word read: outputs clear asynchronously, no response.
    start_req(1'b0, 1'b1, 16'h2000, 16'h0000);
    @(negedge clk);
    check("rstmid_strobe_on", bus_read, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_strobes", {bus_read, bus_write}, 0);
    check("rstmid_addr", bus_address_out, 0);
    check("rstmid_ready", req_ready, 1);
    check("rstmid_rdata", resp_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("rstmid_no_resp", seen, 0);
    start_req(1'b0, 1'b0, 16'h1234, 16'h0000);
    wait_resp(k, rd_cyc, wr_cyc);
    check("after_rst_latency", k, 4);
    check("after_rst_rdata", resp_rdata, 16'h003E);

    // Responder that never answers.
    mute = 1'b1;
    start_req(1'b0, 1'b1, 16'h4000, 16'h0000);
`ifdef BUS_TIMEOUT_EN
    wait_resp(k, rd_cyc, wr_cyc);
    check("tmo_latency", k, 5);
    check("tmo_strobe_cycles", rd_cyc, 4);
    check("tmo_error", resp_error, 1);
    check("tmo_rdata", resp_rdata, 0);
    @(negedge clk);
    check("tmo_error_pulse_only", {resp_valid, resp_error}, 0);
`else
    seen = 0;
    rd_cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) seen++;
      if (bus_read) rd_cyc++;
    end
    check("no_tmo_no_resp", seen, 0);
    check("no_tmo_strobe_held", rd_cyc, 40);
    check("no_tmo_error", resp_error, 0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    mute = 1'b0;

    check("no_strobe_overlap", overlap_cnt, 0);
    check("no_strobe_while_done", early_strobe_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
